mips_decode_alu: RTL and testbench
==================================

// Module: mips_decode_alu
// PURPOSE
//   Decode and execute core of the single-cycle MIPS32 datapath: main control, ALU-control and 32-bit ALU in one block.
//   Takes the fetched instruction and register/immediate operands; returns datapath control strobes, ALU result and zero flag.
//   All outputs are registered (one-stage boundary) so the block can be retimed into a pipelined build.
// PARAMETERS
//   WIDTH  32  datapath width of operands and result
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      reset, asynchronous, active-high
//   in_valid     in   1      instr/operands valid this cycle
//   instr        in   32     instruction word; uses [31:26] opcode, [5:0] funct
//   rs_data      in   WIDTH  register-file read port 1 (ALU operand A)
//   rt_data      in   WIDTH  register-file read port 2
//   imm_ext      in   WIDTH  sign-extended instr[15:0]
//   out_valid    out  1      registered in_valid
//   reg_dst      out  1      1 = write rd (instr[15:11]), 0 = rt
//   branch       out  1      beq
//   mem_read     out  1      load
//   mem_to_reg   out  1      writeback from memory
//   alu_op       out  2      00 add, 01 sub, 10 funct-decoded
//   mem_write    out  1      store
//   alu_src      out  1      1 = operand B is imm_ext, 0 = rt_data
//   reg_write    out  1      register-file write enable
//   jump         out  1      j
//   alu_ctrl     out  4      decoded ALU operation
//   alu_result   out  WIDTH  ALU result
//   alu_zero     out  1      alu_result == 0
// BEHAVIOUR
//   Single clock domain; one clock, reset is asynchronous and active-high.
//   While rst=1, every output is 0, including out_valid and alu_result.
//   Latency: 1 cycle. The posedge after in_valid=1 loads every output from that cycle's inputs.
//   in_valid=0: out_valid<=0; all other outputs hold their last value.
//   Main control by opcode; fields are RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp:
//     000000 R-type: 1,0,0,1,0,0,0,0,10
//     100011 lw:     0,1,1,1,1,0,0,0,00
//     101011 sw:     0,1,0,0,0,1,0,0,00
//     000100 beq:    0,0,0,0,0,0,1,0,01
//     001000 addi:   0,1,0,1,0,0,0,0,00
//     000010 j:      0,0,0,0,0,0,0,1,00
//     other:         all 0 (no write, no memory access)
//   ALU control:
//     alu_op=00 -> 0010; alu_op=01 -> 0110; alu_op=11 -> 0010
//     alu_op=10 by funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001,
//       100111 -> 1100, 101010 -> 0111; any other funct -> 0010
//   ALU, with B = alu_src ? imm_ext : rt_data:
//     0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 signed A<B -> 1 else 0; 1100 ~(A|B)
//     undefined codes -> 0
//     add/sub wrap modulo 2^WIDTH; no overflow trap or flag
//   alu_zero is computed from the same-cycle combinational result and registered together with it.
//   Reset asserted mid-stream clears outputs immediately; the first valid after deassertion is processed normally.
// TESTING
//   R add: instr=0x00221820, rs=5, rt=7 -> next edge alu_result=12, reg_dst=1, reg_write=1, alu_ctrl=0010, zero=0.
//   R sub/slt: rs=-3 (0xFFFFFFFD), rt=2 -> funct 100010 gives 0xFFFFFFFB; funct 101010 gives 1; rs=rt=9 with sub gives zero=1.
//   lw 0x8C220004, rs=0x100, imm=4 -> result=0x104, alu_src=1, mem_read=1, mem_to_reg=1; sw 0xAC220004 -> mem_write=1, reg_write=0.
//   beq 0x10220003, rs=rt=0x55 -> branch=1, alu_ctrl=0110, zero=1; j 0x08000010 -> jump=1, reg_write=0.
//   Logic ops: rs=0xF0F0F0F0, rt=0x0FF00FF0 -> and 0x00F000F0, or 0xFFF0FFF0, nor 0x000F000F; add 0x7FFFFFFF+1 -> 0x80000000.
//   Reset/valid: rst high mid-stream -> all outputs 0 asynchronously; in_valid=0 -> out_valid=0, other outputs hold; unknown opcode 0x3F -> all strobes 0.

Source files
------------

// File: rtl/mips_decode_alu.sv
// Decode and execute core of the single-cycle MIPS32 datapath.
// Main control, ALU control and the ALU share one block; every output
// is registered so the block can later be cut into a pipeline stage.
module mips_decode_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm_ext,
    output logic             out_valid,
    output logic             reg_dst,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic             jump,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             c_reg_dst;
    logic             c_alu_src;
    logic             c_mem_to_reg;
    logic             c_reg_write;
    logic             c_mem_read;
    logic             c_mem_write;
    logic             c_branch;
    logic             c_jump;
    logic [1:0]       c_alu_op;
    logic [3:0]       c_alu_ctrl;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] c_result;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Main control: opcode to datapath strobes; unknown opcodes are inert.
    always_comb begin
        c_reg_dst    = 1'b0;
        c_alu_src    = 1'b0;
        c_mem_to_reg = 1'b0;
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_branch     = 1'b0;
        c_jump       = 1'b0;
        c_alu_op     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                c_reg_dst   = 1'b1;
                c_reg_write = 1'b1;
                c_alu_op    = 2'b10;
            end
            OP_LW: begin
                c_alu_src    = 1'b1;
                c_mem_to_reg = 1'b1;
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
            end
            OP_SW: begin
                c_alu_src   = 1'b1;
                c_mem_write = 1'b1;
            end
            OP_BEQ: begin
                c_branch = 1'b1;
                c_alu_op = 2'b01;
            end
            OP_ADDI: begin
                c_alu_src   = 1'b1;
                c_reg_write = 1'b1;
            end
            OP_J: begin
                c_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control: alu_op selects fixed add/sub or a funct-field decode.
    always_comb begin
        c_alu_ctrl = ALU_ADD;
        case (c_alu_op)
            2'b01: c_alu_ctrl = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  c_alu_ctrl = ALU_ADD;
                    FN_SUB:  c_alu_ctrl = ALU_SUB;
                    FN_AND:  c_alu_ctrl = ALU_AND;
                    FN_OR:   c_alu_ctrl = ALU_OR;
                    FN_NOR:  c_alu_ctrl = ALU_NOR;
                    FN_SLT:  c_alu_ctrl = ALU_SLT;
                    default: c_alu_ctrl = ALU_ADD;
                endcase
            end
            default: c_alu_ctrl = ALU_ADD;
        endcase
    end

    assign operand_b = c_alu_src ? imm_ext : rt_data;

    // ALU: add/sub wrap silently, slt compares as two's complement.
    always_comb begin
        c_result = '0;
        case (c_alu_ctrl)
            ALU_AND: c_result = rs_data & operand_b;
            ALU_OR:  c_result = rs_data | operand_b;
            ALU_ADD: c_result = rs_data + operand_b;
            ALU_SUB: c_result = rs_data - operand_b;
            ALU_SLT: c_result = {{(WIDTH-1){1'b0}},
                                 ($signed(rs_data) < $signed(operand_b))};
            ALU_NOR: c_result = ~(rs_data | operand_b);
            default: c_result = '0;
        endcase
    end

    // Output register: load everything on a valid cycle, otherwise hold
    // all but out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            reg_dst    <= 1'b0;
            branch     <= 1'b0;
            mem_read   <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_op     <= 2'b00;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            jump       <= 1'b0;
            alu_ctrl   <= 4'b0000;
            alu_result <= '0;
            alu_zero   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                reg_dst    <= c_reg_dst;
                branch     <= c_branch;
                mem_read   <= c_mem_read;
                mem_to_reg <= c_mem_to_reg;
                alu_op     <= c_alu_op;
                mem_write  <= c_mem_write;
                alu_src    <= c_alu_src;
                reg_write  <= c_reg_write;
                jump       <= c_jump;
                alu_ctrl   <= c_alu_ctrl;
                alu_result <= c_result;
                alu_zero   <= (c_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_mips_decode_alu.sv
// Bench for mips_decode_alu: directed instruction cases followed by random
// instructions, all compared against an instruction-level reference model.
module tb_mips_decode_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        reg_dst;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        jump;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        valid;
        logic        reg_dst;
        logic        branch;
        logic        mem_read;
        logic        mem_to_reg;
        logic [1:0]  alu_op;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic        jump;
        logic [3:0]  alu_ctrl;
        logic [31:0] result;
        logic        zero;
    } exp_t;

    exp_t exp_q;

    mips_decode_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm_ext    (imm_ext),
        .out_valid  (out_valid),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .jump       (jump),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: what each instruction means, written per instruction kind.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        logic [5:0] op, fn;
        e = '0;
        e.valid = 1'b1;
        op = ins[31:26];
        fn = ins[5:0];
        e.alu_ctrl = 4'b0010;
        e.result = a + b;
        if (op == 6'd0) begin
            e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10;
            if (fn == 6'h22)      begin e.alu_ctrl = 4'b0110; e.result = a - b; end
            else if (fn == 6'h24) begin e.alu_ctrl = 4'b0000; e.result = a & b; end
            else if (fn == 6'h25) begin e.alu_ctrl = 4'b0001; e.result = a | b; end
            else if (fn == 6'h27) begin e.alu_ctrl = 4'b1100; e.result = ~(a | b); end
            else if (fn == 6'h2A) begin
                e.alu_ctrl = 4'b0111;
                e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
        end else if (op == 6'h23) begin
            e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.mem_read = 1;
            e.result = a + imm;
        end else if (op == 6'h2B) begin
            e.alu_src = 1; e.mem_write = 1;
            e.result = a + imm;
        end else if (op == 6'h04) begin
            e.branch = 1; e.alu_op = 2'b01; e.alu_ctrl = 4'b0110;
            e.result = a - b;
        end else if (op == 6'h08) begin
            e.alu_src = 1; e.reg_write = 1;
            e.result = a + imm;
        end else if (op == 6'h02) begin
            e.jump = 1;
        end
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, exp_q.valid});
        check({tag, ".reg_dst"},    {31'd0, reg_dst},    {31'd0, exp_q.reg_dst});
        check({tag, ".branch"},     {31'd0, branch},     {31'd0, exp_q.branch});
        check({tag, ".mem_read"},   {31'd0, mem_read},   {31'd0, exp_q.mem_read});
        check({tag, ".mem_to_reg"}, {31'd0, mem_to_reg}, {31'd0, exp_q.mem_to_reg});
        check({tag, ".alu_op"},     {30'd0, alu_op},     {30'd0, exp_q.alu_op});
        check({tag, ".mem_write"},  {31'd0, mem_write},  {31'd0, exp_q.mem_write});
        check({tag, ".alu_src"},    {31'd0, alu_src},    {31'd0, exp_q.alu_src});
        check({tag, ".reg_write"},  {31'd0, reg_write},  {31'd0, exp_q.reg_write});
        check({tag, ".jump"},       {31'd0, jump},       {31'd0, exp_q.jump});
        check({tag, ".alu_ctrl"},   {28'd0, alu_ctrl},   {28'd0, exp_q.alu_ctrl});
        check({tag, ".result"},     alu_result,          exp_q.result);
        check({tag, ".zero"},       {31'd0, alu_zero},   {31'd0, exp_q.zero});
    endtask

    // Drive one cycle at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk);
        in_valid = v;
        instr    = ins;
        rs_data  = a;
        rt_data  = b;
        imm_ext  = imm;
        @(posedge clk);
        #1;
        if (v) exp_q = model(ins, a, b, imm);
        else   exp_q.valid = 1'b0;
        check_all(tag);
    endtask

    logic [5:0] ops [8];
    logic [5:0] fns [7];

    initial begin
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h08; ops[5] = 6'h02; ops[6] = 6'h3F; ops[7] = 6'h00;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;
        fns[4] = 6'h27; fns[5] = 6'h2A; fns[6] = 6'h21;

        rst = 1'b1; in_valid = 1'b0; instr = '0;
        rs_data = '0; rt_data = '0; imm_ext = '0;
        exp_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("r_add",  1, 32'h00221820, 32'd5, 32'd7, 32'h00001820);
        step("r_sub",  1, 32'h00221822, 32'hFFFFFFFD, 32'd2, 32'h00001822);
        step("r_slt",  1, 32'h0022182A, 32'hFFFFFFFD, 32'd2, 32'h0000182A);
        step("r_subz", 1, 32'h00221822, 32'd9, 32'd9, 32'h00001822);
        step("lw",     1, 32'h8C220004, 32'h100, 32'h3, 32'd4);
        step("sw",     1, 32'hAC220004, 32'h100, 32'h3, 32'd4);
        step("beq",    1, 32'h10220003, 32'h55, 32'h55, 32'd3);
        step("j",      1, 32'h08000010, 32'h1, 32'h2, 32'h10);
        step("and",    1, 32'h00221824, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h1824);
        step("or",     1, 32'h00221825, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h1825);
        step("nor",    1, 32'h00221827, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h1827);
        step("addwrap",1, 32'h00221820, 32'h7FFFFFFF, 32'd1, 32'h1820);
        step("hold",   0, 32'h00221822, 32'h1234, 32'h5678, 32'h0);
        step("hold2",  0, 32'h8C220004, 32'hAAAA, 32'h5555, 32'h4);
        step("unk_op", 1, 32'hFC221820, 32'h11, 32'h22, 32'h1820);

        // Asynchronous reset between clock edges.
        step("pre_rst", 1, 32'h8C220004, 32'h100, 32'h3, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        exp_q = '0;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1, 32'h00221820, 32'd5, 32'd7, 32'h1820);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ins, a, b;
            ins = $urandom;
            ins[31:26] = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
            if (ins[31:26] == 6'd0 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 6)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            step("rand", ($urandom_range(0, 4) != 0), ins, a, b,
                 {{16{ins[15]}}, ins[15:0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
